// File: rtl/inc16_unit_pkg.sv
// Shared types for the relay incrementer stage: datapath width, FSM states, address type.
package relay_pkg;

    localparam int unsigned ADDR_W = 16;

    typedef enum logic [1:0] {INC_IDLE, INC_SETTLE, INC_DONE} inc_state_t;

    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/inc16_unit_if.sv
// Handshake/bus bundle between the address source, inc16_unit and the INC register.
// INC16_DECREMENT_EN adds the dec request bit.
interface inc16_unit_if #(
    parameter int unsigned N = relay_pkg::ADDR_W
);
    logic [N-1:0] addr_in;
    logic         start;
    logic         ld_inc;
    logic [N-1:0] inc_out;
    logic         inc_valid;
    logic         carry_out;
    logic         busy;
`ifdef INC16_DECREMENT_EN
    logic         dec;

    modport master (
        output addr_in, start, ld_inc, dec,
        input  inc_out, inc_valid, carry_out, busy
    );

    modport slave (
        input  addr_in, start, ld_inc, dec,
        output inc_out, inc_valid, carry_out, busy
    );
`else
    modport master (
        output addr_in, start, ld_inc,
        input  inc_out, inc_valid, carry_out, busy
    );

    modport slave (
        input  addr_in, start, ld_inc,
        output inc_out, inc_valid, carry_out, busy
    );
`endif
endinterface

// File: rtl/inc16_unit_counter.sv
// Loadable down-counter modelling relay ripple-carry settling time; stops at zero.
module inc_settle_counter #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/inc16_unit.sv
// Relay incrementer stage: captures addr on start, waits SETTLE_CYCLES, presents addr+1.
// Define INC16_DECREMENT_EN to add the dec input (operand-1, carry_out becomes borrow).
module inc16_unit
    import relay_pkg::*;
#(
    parameter int unsigned N             = ADDR_W,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input logic         clk,
    input logic         reset,
    inc16_unit_if.slave bus
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] LoadVal = CntW'(SETTLE_CYCLES);

    inc_state_t   state_q;
    logic [N-1:0] operand_q;
    logic [N-1:0] inc_out_q, inc_out_d;
    logic         carry_q, carry_d;
    logic         valid_q;
    logic         busy_q;
    logic         cnt_load;
    logic         cnt_zero;
`ifdef INC16_DECREMENT_EN
    logic         dec_q;
`endif

    // Counter loads on any honoured start, i.e. outside SETTLE.
    assign cnt_load = bus.start && (state_q != INC_SETTLE);

    inc_settle_counter #(
        .Width(CntW)
    ) u_counter (
        .clk_i     (clk),
        .reset_i   (reset),
        .load_i    (cnt_load),
        .load_val_i(LoadVal),
        .en_i      (state_q == INC_SETTLE),
        .zero_o    (cnt_zero)
    );

    always_comb begin
        inc_out_d = operand_q + N'(1);
        carry_d   = &operand_q;
`ifdef INC16_DECREMENT_EN
        if (dec_q) begin
            inc_out_d = operand_q - N'(1);
            carry_d   = (operand_q == '0);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INC_IDLE;
            operand_q <= '0;
            inc_out_q <= '0;
            carry_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef INC16_DECREMENT_EN
            dec_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                INC_IDLE: begin
                    if (bus.start) begin
                        operand_q <= bus.addr_in;
`ifdef INC16_DECREMENT_EN
                        dec_q     <= bus.dec;
`endif
                        state_q   <= INC_SETTLE;
                        busy_q    <= 1'b1;
                    end
                end
                INC_SETTLE: begin
                    if (cnt_zero) begin
                        inc_out_q <= inc_out_d;
                        carry_q   <= carry_d;
                        state_q   <= INC_DONE;
                        busy_q    <= 1'b0;
                        valid_q   <= 1'b1;
                    end
                end
                INC_DONE: begin
                    // A new start wins over the acknowledge.
                    if (bus.start) begin
                        operand_q <= bus.addr_in;
`ifdef INC16_DECREMENT_EN
                        dec_q     <= bus.dec;
`endif
                        state_q   <= INC_SETTLE;
                        busy_q    <= 1'b1;
                        valid_q   <= 1'b0;
                    end else if (bus.ld_inc) begin
                        state_q   <= INC_IDLE;
                        valid_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= INC_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inc_out   = inc_out_q;
    assign bus.carry_out = carry_q;
    assign bus.inc_valid = valid_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/inc16_unit.md
Name: inc16_unit

Overview:
- Sixteen-bit incrementer stage that feeds the INC holding register.
- Samples the address bus on a start strobe and models relay ripple-carry settling with a programmable delay.
- After the delay, presents address+1 on inc_out with a valid flag.
- The downstream INC register captures inc_out when its load (ldINC) is asserted, which acknowledges the result.

Parameters:
- N, 16, datapath width in bits.
- SETTLE_CYCLES, 4, clock cycles of modelled relay settling after capture; legal range 0..255.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- addr_in  input  N  address bus value to be incremented.
- start  input  1  capture addr_in and begin settling; honoured in IDLE and DONE, ignored in SETTLE.
- ld_inc  input  1  downstream INC register load strobe; acknowledges the result in DONE.
- inc_out  output  N  registered result addr+1, modulo 2^N.
- inc_valid  output  1  high in DONE; inc_out is stable and correct.
- carry_out  output  1  registered; high when the captured value was all-ones (wrap to 0).
- busy  output  1  high in SETTLE.

Behaviour:
- Reset values:
  - state=IDLE; inc_out=0; carry_out=0; inc_valid=0; busy=0; settle counter=0.
- Reset takes priority over every other input in every state. Reset mid-SETTLE abandons the operation with no partial result.
- IDLE:
  - start=1: capture addr_in into operand register, load counter with SETTLE_CYCLES, go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE:
  - busy=1; counter decrements each cycle.
  - When counter==0: write inc_out=operand+1 and carry_out=(operand==all-ones), go to DONE.
  - start and ld_inc are ignored.
- DONE:
  - inc_valid=1; inc_out and carry_out are held.
  - start=1 has priority over ld_inc: recapture and go to SETTLE; inc_valid drops the next cycle.
  - ld_inc=1 alone: go to IDLE; inc_out and carry_out keep their last value.
- Latency:
  - start sampled at edge t gives inc_valid=1 after edge t+1+SETTLE_CYCLES.
  - SETTLE_CYCLES=0 gives one-cycle latency; SETTLE still lasts one cycle.
- Arithmetic:
  - N-bit unsigned increment; carry out of the MSB goes to carry_out only.
  - 0xFFFF gives inc_out=0x0000, carry_out=1.
- inc_out changes only on the SETTLE-to-DONE transition (and on reset). The downstream register never sees intermediate values.
- ld_inc in IDLE has no effect. The downstream register then reloads the held inc_out, which is harmless.

Optional Feature:
- Macro: INC16_DECREMENT_EN.
- Defined:
  - Adds input port dec (1 bit), sampled together with addr_in on start.
  - dec=1 computes operand-1 modulo 2^N.
  - carry_out then means borrow, high when the operand was 0x0000 (result 0xFFFF).
  - Timing and handshake are unchanged.
- Undefined: port dec is absent and the block only increments.

Decomposition:
- Shared package relay_pkg holds:
  - localparam ADDR_W=16;
  - typedef enum logic [1:0] {INC_IDLE, INC_SETTLE, INC_DONE} inc_state_t;
  - typedef logic [ADDR_W-1:0] addr_t.
- One sub-module, inc_settle_counter:
  - Loadable down-counter: load, load value, zero flag, synchronous reset.
  - Width $clog2(SETTLE_CYCLES+1), minimum 1.
- Top level holds the FSM, operand register and adder.

Test Plan:
- Reset, then SETTLE_CYCLES=4, addr_in=0x1234, start pulse:
  - busy=1 for 5 cycles;
  - inc_valid rises 5 cycles after the start edge with inc_out=0x1235, carry_out=0;
  - ld_inc then returns to IDLE with inc_out held at 0x1235.
- Wrap case, addr_in=0xFFFF, start: inc_out=0x0000, carry_out=1 in DONE.
- Busy protection:
  - start with 0x0010, then start with 0x0020 and ld_inc asserted during SETTLE;
  - result is 0x0011; the FSM is still in DONE.
- Priority in DONE:
  - start (addr_in=0x00FF) and ld_inc asserted in the same cycle;
  - block re-enters SETTLE; final inc_out=0x0100.
- Reset mid-operation:
  - assert reset on the 2nd SETTLE cycle of 0x4000;
  - next cycle: inc_out=0, busy=0, inc_valid=0, state=IDLE.
- With INC16_DECREMENT_EN and SETTLE_CYCLES=0:
  - dec=1, addr_in=0x0000: inc_valid one cycle after the start edge, inc_out=0xFFFF, carry_out=1;
  - dec=1, addr_in=0x0100: inc_out=0x00FF, carry_out=0.
